bnn_image_loader: RTL

//  Upstream feeder of the BNN image decode stage. Accepts a host byte stream (one image row
//  per beat) over a valid/ready handshake, and drives the per-row write strobe and row select.

---
 rtl/bnn_pkg.sv | 10 +
 rtl/flopenr.sv | 17 +
 rtl/bnn_image_loader.sv | 83 ++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared image geometry, row/image types and loader state encoding
package bnn_pkg;
    localparam int IMG_ROWS = 8;
    localparam int IMG_COLS = 8;

    typedef logic [IMG_COLS-1:0] row_t;
    typedef row_t [IMG_ROWS-1:0] image_t;

    typedef enum logic {LOAD, VALID} ldr_state_t;
endpackage

// File: rtl/flopenr.sv
// rtl/flopenr.sv - enabled register with synchronous active-high clear
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/bnn_image_loader.sv
// rtl/bnn_image_loader.sv - assembles host row beats into a binary image for the BNN core
module bnn_image_loader
    import bnn_pkg::*;
#(
    parameter int ROWS = IMG_ROWS,
    parameter int COLS = IMG_COLS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [COLS-1:0]             s_data_i,
    input  logic                        s_valid_i,
    input  logic                        s_last_i,
    output logic                        s_ready_o,
    output logic [$clog2(ROWS)-1:0]     row_sel_o,
    output logic                        row_en_o,
    output logic [ROWS-1:0][COLS-1:0]   image_o,
    output logic                        image_valid_o,
    input  logic                        image_ready_i,
    output logic                        err_o
);
    localparam int RW = $clog2(ROWS);

    ldr_state_t    state, state_nxt;
    logic [RW-1:0] row_cnt, row_cnt_nxt;
    logic          err_nxt;
    logic          last_row;

    assign s_ready_o     = (state == LOAD);
    assign image_valid_o = (state == VALID);
    assign row_en_o      = s_valid_i & s_ready_o;
    assign row_sel_o     = row_cnt;
    assign last_row      = (row_cnt == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD;
            row_cnt <= '0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_cnt_nxt;
            err_o   <= err_nxt;
        end
    end

    // A frame completes only when s_last_i and the final row coincide; any other
    // placement of s_last_i discards the partial frame and flags an error.
    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        err_nxt     = 1'b0;
        case (state)
            LOAD: begin
                if (row_en_o) begin
                    if (last_row && s_last_i) begin
                        state_nxt   = VALID;
                        row_cnt_nxt = '0;
                    end else if (!last_row && !s_last_i) begin
                        row_cnt_nxt = row_cnt + RW'(1);
                    end else begin
                        err_nxt     = 1'b1;
                        row_cnt_nxt = '0;
                    end
                end
            end
            VALID: begin
                if (image_ready_i)
                    state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        flopenr #(.WIDTH(COLS)) u_row (
            .clk (clk),
            .rst (rst),
            .en  (row_en_o && (row_sel_o == RW'(r))),
            .d   (s_data_i),
            .q   (image_o[r])
        );
    end
endmodule
